// File: rtl/fb_arbiter.sv
// fb_arbiter: frame-buffer SRAM arbiter between a display-side reader and a
// capture-side writer sharing one asynchronous SRAM port.
// Reads take two cycles (address, data) and can run back to back; writes take
// a setup cycle and a one-cycle WE_N pulse, then always return to S_IDLE.
// That idle cycle is the bus turnaround.
// Optional build macro FB_ARB_STARVE_GUARD_EN adds a write-starvation counter.
// With the macro, a write that has waited STARVE_MAX cycles beats a pending read.
// Without the macro, reads always have strict priority.
module fb_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_dq_out_o,
    input  logic [DATA_W-1:0] sram_dq_in_i,
    output logic              sram_dq_oe_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_S,
        S_WR_P
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_dq_out_q, sram_dq_out_d;
    logic              sram_dq_oe_q, sram_dq_oe_d;
    logic              sram_oe_n_q, sram_oe_n_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              arb_en;
    logic              force_wr;

    // A starvation threshold below one cycle is meaningless.
    // This named block is elaborated only for such an illegal value.
    if (STARVE_MAX < 1) begin : g_bad_starve_max
    end

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Count cycles a write waits ungranted, saturating at STARVE_MAX.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!wr_req_i || wr_gnt_q) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_W'(STARVE_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_wr = wr_req_i && (wait_cnt_q == CNT_W'(STARVE_MAX));
`else
    assign force_wr = 1'b0;
`endif

    // Next-state logic and registered SRAM/handshake outputs.
    always_comb begin
        state_d       = state_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        sram_dq_oe_d  = sram_dq_oe_q;
        sram_oe_n_d   = sram_oe_n_q;
        sram_we_n_d   = sram_we_n_q;
        rd_gnt_d      = 1'b0;
        wr_gnt_d      = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        arb_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb_en = 1'b1;
            end
            S_RD_A: begin
                state_d = S_RD_D;
            end
            S_RD_D: begin
                // Capture the read word, then fall back to idle unless re-arbitrated.
                rd_data_d   = sram_dq_in_i;
                rd_valid_d  = 1'b1;
                sram_oe_n_d = 1'b1;
                state_d     = S_IDLE;
                arb_en      = 1'b1;
            end
            S_WR_S: begin
                sram_we_n_d = 1'b0;
                state_d     = S_WR_P;
            end
            S_WR_P: begin
                // Release the bus; the mandatory pass through S_IDLE is the turnaround.
                sram_we_n_d  = 1'b1;
                sram_dq_oe_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arb_en) begin
            if (wr_req_i && (!rd_req_i || force_wr)) begin
                sram_addr_d   = wr_addr_i;
                sram_dq_out_d = wr_data_i;
                sram_dq_oe_d  = 1'b1;
                wr_gnt_d      = 1'b1;
                state_d       = S_WR_S;
            end else if (rd_req_i) begin
                sram_addr_d = rd_addr_i;
                sram_oe_n_d = 1'b0;
                rd_gnt_d    = 1'b1;
                state_d     = S_RD_A;
            end
        end
    end

    // State and output registers; reset immediately frees the SRAM bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
            rd_gnt_q      <= 1'b0;
            wr_gnt_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_oe_n_q   <= sram_oe_n_d;
            sram_we_n_q   <= sram_we_n_d;
            rd_gnt_q      <= rd_gnt_d;
            wr_gnt_q      <= wr_gnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_gnt_o      = rd_gnt_q;
    assign wr_gnt_o      = wr_gnt_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign sram_addr_o   = sram_addr_q;
    assign sram_dq_out_o = sram_dq_out_q;
    assign sram_dq_oe_o  = sram_dq_oe_q;
    assign sram_oe_n_o   = sram_oe_n_q;
    assign sram_we_n_o   = sram_we_n_q;

endmodule
